// File: rtl/mem_arb_pkg.sv
// Shared encodings for the IF/D memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/arb_starve_counter.sv
// Grant selection between IF and D, with a saturating count of D grants
// taken while IF was waiting so IF cannot be starved indefinitely.
module arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   if_req,
    input  logic   d_req,
    input  logic   in_idle,
    output logic   grant_valid,
    output owner_t grant_owner
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             force_if;

    always_comb begin
        force_if    = (starve_cnt >= CNT_MAX);
        grant_valid = if_req | d_req;
        grant_owner = (d_req && !(if_req && force_if)) ? OWN_D : OWN_IF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (in_idle) begin
            if (!if_req || grant_owner == OWN_IF) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_MAX) begin
                // if_req is high and D won the grant
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch (IF) and
// the memory stage (D); one access in flight, fixed RAM read latency.
//
// state | meaning
// IDLE  | no access in flight; arbitrate and latch the winning request
// ISSUE | ram_en high for this one cycle with the latched addr/we/wdata
// WAIT  | counting down MEM_LAT; read data captured on the terminal count
// DONE  | owner's ready pulses for one cycle
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              stallF,
    output logic              stallM,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT);

    arb_state_t           state;
    owner_t               owner;
    logic                 req_we;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic                 in_idle;
    logic                 grant_valid;
    owner_t               grant_owner;

    assign in_idle = (state == IDLE);

    arb_starve_counter #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .d_req      (d_req),
        .in_idle    (in_idle),
        .grant_valid(grant_valid),
        .grant_owner(grant_owner)
    );

    assign stallF = if_req & ~if_ready;
    assign stallM = d_req & ~d_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            req_we    <= 1'b0;
            lat_cnt   <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        // ram_addr/ram_wdata double as the latched request
                        owner  <= grant_owner;
                        ram_en <= 1'b1;
                        state  <= ISSUE;
                        if (grant_owner == OWN_D) begin
                            req_we    <= d_we;
                            ram_we    <= d_we;
                            ram_addr  <= d_addr;
                            ram_wdata <= d_wdata;
                        end else begin
                            req_we    <= 1'b0;
                            ram_we    <= 1'b0;
                            ram_addr  <= if_addr;
                            ram_wdata <= '0;
                        end
                    end
                end
                ISSUE: begin
                    ram_en  <= 1'b0;
                    ram_we  <= 1'b0;
                    lat_cnt <= LAT_LOAD;
                    state   <= WAIT;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == LAT_CNT_W'(1)) begin
                        state <= DONE;
                        if (owner == OWN_D) begin
                            d_ready <= 1'b1;
                            if (!req_we) d_rdata <= ram_rdata;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= ram_rdata;
                        end
                    end
                end
                DONE: begin
                    if_ready <= 1'b0;
                    d_ready  <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a MEM_LAT=2 instance for the main
// scenarios and a MEM_LAT=1 instance for the short-latency capture timing.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] if_rdata, d_rdata, ram_addr, ram_wdata, ram_rdata;
    logic        if_ready, d_ready, stallF, stallM, ram_en, ram_we;

    logic        if_req_1 = 1'b0;
    logic [31:0] if_addr_1 = '0;
    logic        d_req_1 = 1'b0, d_we_1 = 1'b0;
    logic [31:0] d_addr_1 = '0, d_wdata_1 = '0;
    logic [31:0] if_rdata_1, d_rdata_1, ram_addr_1, ram_wdata_1, ram_rdata_1;
    logic        if_ready_1, d_ready_1, stallF_1, stallM_1, ram_en_1, ram_we_1;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .stallF(stallF), .stallM(stallM),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req_1), .if_addr(if_addr_1), .if_rdata(if_rdata_1), .if_ready(if_ready_1),
        .d_req(d_req_1), .d_we(d_we_1), .d_addr(d_addr_1), .d_wdata(d_wdata_1),
        .d_rdata(d_rdata_1), .d_ready(d_ready_1), .stallF(stallF_1), .stallM(stallM_1),
        .ram_en(ram_en_1), .ram_we(ram_we_1), .ram_addr(ram_addr_1),
        .ram_wdata(ram_wdata_1), .ram_rdata(ram_rdata_1)
    );

    // RAM model: unwritten word i reads A5000000^i; data only valid in the
    // exact latency cycle, otherwise a BAD0xxxx filler.
    logic [31:0] mem [0:1023];
    logic [32:0] pipe0 [0:1];
    logic [32:0] pipe1;

    always @(posedge clk) begin
        pipe0[0] <= {ram_en & ~ram_we, mem[ram_addr[11:2]]};
        pipe0[1] <= pipe0[0];
        pipe1    <= {ram_en_1 & ~ram_we_1, mem[ram_addr_1[11:2]]};
        if (ram_en && ram_we) mem[ram_addr[11:2]] <= ram_wdata;
        if (cyc == 0) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 ^ 32'(i);
            mem[16] <= 32'hDEAD_BEEF;
        end
    end

    assign ram_rdata   = pipe0[1][32] ? pipe0[1][31:0] : {16'hBAD0, cyc[15:0]};
    assign ram_rdata_1 = pipe1[32] ? pipe1[31:0] : {16'hBAD0, cyc[15:0]};

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } iss_t;

    typedef struct {
        int          cyc;
        logic        own;
        logic [31:0] data;
    } don_t;

    iss_t q_iss[$];
    don_t q_don[$];
    iss_t q_iss1[$];
    don_t q_don1[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: DUT event with nothing expected (cycle %0d)", name, cyc);
    endtask

    iss_t mi, mi1;
    don_t md, md1;

    always @(negedge clk) begin
        chk("ram_we_qualified", 32'(ram_we & ~ram_en), 32'd0);
        chk("single_ready", 32'(if_ready & d_ready), 32'd0);
        if (ram_en) begin
            if (q_iss.size() == 0) unexpected("ram_en");
            else begin
                mi = q_iss.pop_front();
                chk("issue_cycle", 32'(cyc), 32'(mi.cyc));
                chk("issue_addr", ram_addr, mi.addr);
                chk("issue_we", 32'(ram_we), 32'(mi.we));
                if (mi.we) chk("issue_wdata", ram_wdata, mi.wdata);
            end
        end
        if (if_ready || d_ready) begin
            if (q_don.size() == 0) unexpected("ready");
            else begin
                md = q_don.pop_front();
                chk("ready_cycle", 32'(cyc), 32'(md.cyc));
                chk("ready_owner", 32'(d_ready), 32'(md.own));
                chk("ready_rdata", md.own ? d_rdata : if_rdata, md.data);
            end
        end
        if (ram_en_1) begin
            if (q_iss1.size() == 0) unexpected("lat1_ram_en");
            else begin
                mi1 = q_iss1.pop_front();
                chk("lat1_issue_cycle", 32'(cyc), 32'(mi1.cyc));
                chk("lat1_issue_addr", ram_addr_1, mi1.addr);
            end
        end
        if (if_ready_1 || d_ready_1) begin
            if (q_don1.size() == 0) unexpected("lat1_ready");
            else begin
                md1 = q_don1.pop_front();
                chk("lat1_ready_cycle", 32'(cyc), 32'(md1.cyc));
                chk("lat1_ready_owner", 32'(d_ready_1), 32'(md1.own));
                chk("lat1_if_rdata", if_rdata_1, md1.data);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_iss(input int c, input logic we, input logic [31:0] a, input logic [31:0] w);
        iss_t e;
        e.cyc = c; e.we = we; e.addr = a; e.wdata = w;
        q_iss.push_back(e);
    endtask

    task automatic push_don(input int c, input logic own, input logic [31:0] d);
        don_t e;
        e.cyc = c; e.own = own; e.data = d;
        q_don.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        chk({tag, "_ram_en"}, 32'(ram_en), 32'd0);
        chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        chk({tag, "_ram_addr"}, ram_addr, 32'd0);
        chk({tag, "_ram_wdata"}, ram_wdata, 32'd0);
        chk({tag, "_if_ready"}, 32'(if_ready), 32'd0);
        chk({tag, "_d_ready"}, 32'(d_ready), 32'd0);
        chk({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk({tag, "_d_rdata"}, d_rdata, 32'd0);
        chk({tag, "_stallF"}, 32'(stallF), 32'd0);
        chk({tag, "_stallM"}, 32'(stallM), 32'd0);
    endtask

    int t;
    iss_t e1;
    don_t f1;

    initial begin
        step(3);
        check_zero("reset");
        step(1);
        rst = 1'b0;

        // IF-only read of 0x40
        step(1);
        t = cyc;
        if_req = 1'b1; if_addr = 32'h40;
        push_iss(t + 1, 1'b0, 32'h40, 32'h0);
        push_don(t + 4, 1'b0, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stallF_waiting", 32'(stallF), 32'd1);
        end
        @(negedge clk);
        chk("stallF_at_ready", 32'(stallF), 32'd0);
        step(1);
        if_req = 1'b0;

        // D write 0x12345678 to 0x100; d_rdata stays at its reset value
        step(1);
        t = cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h1234_5678;
        push_iss(t + 1, 1'b1, 32'h100, 32'h1234_5678);
        push_don(t + 4, 1'b1, 32'h0);
        @(negedge clk);
        chk("stallM_waiting", 32'(stallM), 32'd1);
        step(5);
        d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0;

        // D read of 0x100 with d_addr moved to 0x200 after the grant
        step(1);
        t = cyc;
        d_req = 1'b1; d_addr = 32'h100;
        push_iss(t + 1, 1'b0, 32'h100, 32'h0);
        push_don(t + 4, 1'b1, 32'h1234_5678);
        step(1);
        d_addr = 32'h200;
        step(4);
        d_req = 1'b0;

        // both requesters held: D,D,D,D,IF repeating
        step(1);
        t = cyc;
        if_req = 1'b1; if_addr = 32'h80;
        d_req = 1'b1; d_addr = 32'h300;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) begin
                push_iss(t + 5 * k + 1, 1'b0, 32'h80, 32'h0);
                push_don(t + 5 * k + 4, 1'b0, 32'hA500_0020);
            end else begin
                push_iss(t + 5 * k + 1, 1'b0, 32'h300, 32'h0);
                push_don(t + 5 * k + 4, 1'b1, 32'hA500_00C0);
            end
        end
        step(50);
        if_req = 1'b0; d_req = 1'b0;

        // reset while waiting for read data
        step(1);
        t = cyc;
        if_req = 1'b1; if_addr = 32'h40;
        push_iss(t + 1, 1'b0, 32'h40, 32'h0);
        step(2);
        rst = 1'b1; if_req = 1'b0;
        step(1);
        rst = 1'b0;
        check_zero("midreset");
        step(1);
        t = cyc;
        if_req = 1'b1; if_addr = 32'h80;
        push_iss(t + 1, 1'b0, 32'h80, 32'h0);
        push_don(t + 4, 1'b0, 32'hA500_0020);
        step(5);
        if_req = 1'b0;

        // MEM_LAT=1 instance: two back-to-back IF reads
        step(1);
        t = cyc;
        if_req_1 = 1'b1; if_addr_1 = 32'h40;
        e1.cyc = t + 1; e1.we = 1'b0; e1.addr = 32'h40; e1.wdata = 32'h0;
        q_iss1.push_back(e1);
        f1.cyc = t + 3; f1.own = 1'b0; f1.data = 32'hDEAD_BEEF;
        q_don1.push_back(f1);
        e1.cyc = t + 5; e1.addr = 32'h80;
        q_iss1.push_back(e1);
        f1.cyc = t + 7; f1.data = 32'hA500_0020;
        q_don1.push_back(f1);
        step(4);
        if_addr_1 = 32'h80;
        step(4);
        if_req_1 = 1'b0;

        step(4);
        chk("issue_queue_drained", 32'(q_iss.size()), 32'd0);
        chk("ready_queue_drained", 32'(q_don.size()), 32'd0);
        chk("lat1_issue_queue_drained", 32'(q_iss1.size()), 32'd0);
        chk("lat1_ready_queue_drained", 32'(q_don1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
